sonic_vc_st_rl_adapter: RTL and testbench
=========================================

# sonic_vc_st_rl_adapter

Parametrised Avalon-ST ready-latency adapter for the SoNIC VC receive/transmit datapaths. It joins an upstream source with ready latency IN_RL to a downstream sink with ready latency OUT_RL. A DEPTH-entry skid FIFO absorbs beats already in flight when backpressure is applied, so no beat is lost and full throughput is sustained. Unlike the fixed pass-through timing adapters, it detects upstream protocol violations and counts dropped beats.

## Interface
- DATA_W, 128, data bus width
- EMPTY_W, 2, empty field width
- IN_RL, 0, upstream ready latency (0..4)
- OUT_RL, 2, downstream ready latency (0..4)
- ADDR_W, 3, FIFO address width; DEPTH = 2**ADDR_W; DEPTH ≥ IN_RL+OUT_RL+2 is required (elaboration error otherwise)
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  grant: a beat may arrive IN_RL cycles later
- in_valid  in  1  upstream beat valid
- in_data  in  DATA_W  payload
- in_startofpacket, in_endofpacket  in  1 each  packet delimiters
- in_empty  in  EMPTY_W  empty symbols on EOP beat
- out_ready  in  1  downstream ready (latency OUT_RL)
- out_valid  out  1  beat transferred when high
- out_data, out_startofpacket, out_endofpacket, out_empty  out  as input  FIFO head payload
- overflow_err  out  1  sticky: ungranted beat seen
- drop_count  out  16  saturating count of dropped beats

## Operation
- Payload word {data, sop, eop, empty} is stored in a register-array FIFO with wr_ptr, rd_ptr (ADDR_W bits, natural wrap) and count (ADDR_W+1 bits, 0..DEPTH).
- Grant tracking: grant_sr is an IN_RL-bit shift register of past in_ready values. grant_sr[IN_RL-1] is the grant issued IN_RL cycles ago. outstanding = popcount(grant_sr).
- in_ready = !reset && (count + outstanding < DEPTH). The output is combinational from registers only.
- Arrival permitted:
  - IN_RL=0: permitted = in_ready.
  - IN_RL>0: permitted = grant_sr[IN_RL-1].
- Push: in_valid && permitted → write at wr_ptr, wr_ptr+1.
- Drop: in_valid && !permitted → beat discarded, overflow_err←1, drop_count+1 saturating at 0xFFFF.
- Downstream permission:
  - OUT_RL=0: out_valid = (count≠0); pop = out_valid && out_ready.
  - OUT_RL>0: rdy_sr is an OUT_RL-deep shift of out_ready; out_valid = (count≠0) && rdy_sr[OUT_RL-1]; pop = out_valid.
- Out payload is always the FIFO head. It holds stable while out_valid && !pop (OUT_RL=0 only).
- count update: count + push − pop. Simultaneous push and pop leaves count unchanged and both pointers advance.
- There is no empty-FIFO bypass: a beat is always registered first.
- Full FIFO: in_ready=0 even if a pop is happening this cycle (conservative). in_ready reasserts the cycle after count drops.
- Packet markers pass through unmodified. No packet integrity checking.

## Timing
- Reset (sampled high at clk edge) clears pointers, count, grant_sr, rdy_sr, overflow_err and drop_count. While reset is high, in_ready=0 and out_valid=0. Mid-operation reset discards all buffered beats.
- First cycle after reset: in_ready=1, out_valid=0.
- Latency: a beat pushed at cycle t can be on out_* at t+1 at the earliest (requires rdy_sr permission at t+1).
- Steady state with out_ready held high: one beat per cycle, no bubbles, for any legal IN_RL/OUT_RL.
- After out_ready deasserts at t, at most OUT_RL further pops occur (t..t+OUT_RL−1). Those pops use permissions already issued.
- After in_ready deasserts at t, up to IN_RL granted beats may still arrive. The credit equation guarantees they fit.

## Test plan
- Reset/idle, IN_RL=0, OUT_RL=2: hold reset 3 cycles, then release → in_ready=0 and out_valid=0 during reset; in_ready=1 on the first cycle after; drop_count=0.
- Streaming, IN_RL=0, OUT_RL=2: 64-beat packet, data=beat index, out_ready constant 1 → 64 beats out in order; sop on beat 0, eop+empty=2 on beat 63; zero bubbles after 3-cycle fill.
- Backpressure, IN_RL=2, OUT_RL=2, DEPTH=8: random out_ready (50%) over 1000 beats → all beats delivered in order; count never exceeds 8; overflow_err stays 0.
- Full/wrap, IN_RL=0, OUT_RL=0: out_ready=0, push until in_ready=0 → exactly 8 beats accepted. Then 1 pop → in_ready=1 next cycle. Run 3 full pointer wraps with no corruption.
- Violation, IN_RL=1: drive in_valid one cycle after in_ready=0 → beat dropped, overflow_err=1 (sticky), drop_count=1. 70000 violations → drop_count=0xFFFF.
- Mid-stream reset: assert reset with count=5 → next cycle count=0 and out_valid=0; no stale beat appears after release.

Source files
------------

// File: rtl/sonic_vc_st_rl_adapter.sv
// Avalon-ST ready-latency adapter with skid FIFO, grant tracking and drop accounting.
// Latency: one cycle minimum from push to out_* (every beat is registered, no bypass).
// Backpressure: in_ready credits count+outstanding grants against DEPTH; out_ready is honoured with latency OUT_RL.
//
// Ports:
//   clk, reset                 sole clock, synchronous active-high reset
//   in_ready/in_valid/in_*     upstream sink side (ready latency IN_RL)
//   out_ready/out_valid/out_*  downstream source side (ready latency OUT_RL)
//   overflow_err               sticky flag, set when an ungranted beat arrives
//   drop_count                 saturating count of discarded beats
module sonic_vc_st_rl_adapter #(
    parameter int DATA_W  = 128,
    parameter int EMPTY_W = 2,
    parameter int IN_RL   = 0,
    parameter int OUT_RL  = 2,
    parameter int ADDR_W  = 3
) (
    input  logic               clk,
    input  logic               reset,
    output logic               in_ready,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               overflow_err,
    output logic [15:0]        drop_count
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WORD_W = DATA_W + 2 + EMPTY_W;
    // Shift registers keep at least one bit so zero-latency builds still elaborate.
    localparam int GSR_W  = (IN_RL  > 0) ? IN_RL  : 1;
    localparam int RSR_W  = (OUT_RL > 0) ? OUT_RL : 1;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int OST_W  = 3;
    localparam int SUM_W  = ADDR_W + 4;

    if (IN_RL < 0 || IN_RL > 4 || OUT_RL < 0 || OUT_RL > 4) begin : g_rl_check
        $error("sonic_vc_st_rl_adapter: IN_RL and OUT_RL must be in 0..4");
    end
    if (DEPTH < IN_RL + OUT_RL + 2) begin : g_depth_check
        $error("sonic_vc_st_rl_adapter: DEPTH must be at least IN_RL+OUT_RL+2");
    end

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [GSR_W-1:0]  grant_sr_q, grant_sr_d;
    logic [RSR_W-1:0]  rdy_sr_q, rdy_sr_d;
    logic              overflow_err_q, overflow_err_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic [OST_W-1:0]  outstanding;
    logic [SUM_W-1:0]  credit_sum;
    logic              permitted;
    logic              push;
    logic              drop;
    logic              pop;
    logic [WORD_W-1:0] in_word;

    assign in_word = {in_data, in_startofpacket, in_endofpacket, in_empty};

    // Grants already issued whose beats may still land count against free space.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < GSR_W; i++) begin
            outstanding = outstanding + OST_W'(grant_sr_q[i]);
        end
    end

    // Conservative credit: a pop in the same cycle does not free a slot until next cycle.
    assign credit_sum = SUM_W'(count_q) + SUM_W'(outstanding);
    assign in_ready   = !reset && (credit_sum < SUM_W'(DEPTH));

    assign permitted  = (IN_RL == 0) ? in_ready : grant_sr_q[GSR_W-1];
    assign push       = !reset && in_valid && permitted;
    assign drop       = !reset && in_valid && !permitted;

    // With OUT_RL>0 the sink already committed to accept, so out_valid itself is the pop.
    assign out_valid  = !reset && (count_q != '0) &&
                        ((OUT_RL == 0) ? 1'b1 : rdy_sr_q[RSR_W-1]);
    assign pop        = (OUT_RL == 0) ? (out_valid && out_ready) : out_valid;

    assign {out_data, out_startofpacket, out_endofpacket, out_empty} = mem_q[rd_ptr_q];
    assign overflow_err = overflow_err_q;
    assign drop_count   = drop_count_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d       = rd_ptr_q + ADDR_W'(pop);
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        grant_sr_d     = (IN_RL == 0)  ? '0 : ((grant_sr_q << 1) | GSR_W'(in_ready));
        rdy_sr_d       = (OUT_RL == 0) ? '0 : ((rdy_sr_q << 1) | RSR_W'(out_ready));
        overflow_err_d = overflow_err_q | drop;
        drop_count_d   = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            grant_sr_q     <= '0;
            rdy_sr_q       <= '0;
            overflow_err_q <= 1'b0;
            drop_count_q   <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            grant_sr_q     <= grant_sr_d;
            rdy_sr_q       <= rdy_sr_d;
            overflow_err_q <= overflow_err_d;
            drop_count_q   <= drop_count_d;
        end
    end

    // Payload storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_word;
        end
    end

endmodule

// File: tb/tb_sonic_vc_st_rl_adapter.sv
module tb_sonic_vc_st_rl_adapter;

    localparam int DW = 128;
    localparam int EW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Instance A: IN_RL=0, OUT_RL=2
    logic a_in_ready, a_in_valid, a_in_sop, a_in_eop, a_out_ready, a_out_valid, a_out_sop, a_out_eop, a_ovf;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [EW-1:0] a_in_empty, a_out_empty;
    logic [15:0]   a_drop;
    // Instance B: IN_RL=2, OUT_RL=2
    logic b_in_ready, b_in_valid, b_in_sop, b_in_eop, b_out_ready, b_out_valid, b_out_sop, b_out_eop, b_ovf;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [EW-1:0] b_in_empty, b_out_empty;
    logic [15:0]   b_drop;
    // Instance C: IN_RL=0, OUT_RL=0
    logic c_in_ready, c_in_valid, c_in_sop, c_in_eop, c_out_ready, c_out_valid, c_out_sop, c_out_eop, c_ovf;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [EW-1:0] c_in_empty, c_out_empty;
    logic [15:0]   c_drop;
    // Instance D: IN_RL=1, OUT_RL=0
    logic d_in_ready, d_in_valid, d_in_sop, d_in_eop, d_out_ready, d_out_valid, d_out_sop, d_out_eop, d_ovf;
    logic [DW-1:0] d_in_data, d_out_data;
    logic [EW-1:0] d_in_empty, d_out_empty;
    logic [15:0]   d_drop;

    sonic_vc_st_rl_adapter #(.DATA_W(DW), .EMPTY_W(EW), .IN_RL(0), .OUT_RL(2), .ADDR_W(3)) dut_a (
        .clk(clk), .reset(reset),
        .in_ready(a_in_ready), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_startofpacket(a_in_sop), .in_endofpacket(a_in_eop), .in_empty(a_in_empty),
        .out_ready(a_out_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_startofpacket(a_out_sop), .out_endofpacket(a_out_eop), .out_empty(a_out_empty),
        .overflow_err(a_ovf), .drop_count(a_drop));

    sonic_vc_st_rl_adapter #(.DATA_W(DW), .EMPTY_W(EW), .IN_RL(2), .OUT_RL(2), .ADDR_W(3)) dut_b (
        .clk(clk), .reset(reset),
        .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_startofpacket(b_in_sop), .in_endofpacket(b_in_eop), .in_empty(b_in_empty),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop), .out_empty(b_out_empty),
        .overflow_err(b_ovf), .drop_count(b_drop));

    sonic_vc_st_rl_adapter #(.DATA_W(DW), .EMPTY_W(EW), .IN_RL(0), .OUT_RL(0), .ADDR_W(3)) dut_c (
        .clk(clk), .reset(reset),
        .in_ready(c_in_ready), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_startofpacket(c_in_sop), .in_endofpacket(c_in_eop), .in_empty(c_in_empty),
        .out_ready(c_out_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_startofpacket(c_out_sop), .out_endofpacket(c_out_eop), .out_empty(c_out_empty),
        .overflow_err(c_ovf), .drop_count(c_drop));

    sonic_vc_st_rl_adapter #(.DATA_W(DW), .EMPTY_W(EW), .IN_RL(1), .OUT_RL(0), .ADDR_W(3)) dut_d (
        .clk(clk), .reset(reset),
        .in_ready(d_in_ready), .in_valid(d_in_valid), .in_data(d_in_data),
        .in_startofpacket(d_in_sop), .in_endofpacket(d_in_eop), .in_empty(d_in_empty),
        .out_ready(d_out_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_startofpacket(d_out_sop), .out_endofpacket(d_out_eop), .out_empty(d_out_empty),
        .overflow_err(d_ovf), .drop_count(d_drop));

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0)
                $display("FAIL reset_hold: in_ready=%b out_valid=%b required 0/0", a_in_ready, a_out_valid);
            else n_pass++;
        end
        @(negedge clk); reset = 1'b0; #1;
        n_total++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", a_in_ready, a_out_valid);
        else n_pass++;
        n_total++;
        if (a_drop !== 16'd0 || a_ovf !== 1'b0)
            $display("FAIL reset_counters: drop_count=%0d overflow_err=%b required 0/0", a_drop, a_ovf);
        else n_pass++;
    endtask

    task automatic test_streaming;
        int sent = 0, got = 0, errs = 0, first_push = -1, first_out = -1, last_out = -1;
        logic last_eop = 1'b0, first_sop = 1'b0;
        logic [EW-1:0] last_empty = '0;
        a_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int cyc = 0; cyc < 300 && got < 64; cyc++) begin
            @(negedge clk);
            a_in_valid = a_in_ready && (sent < 64);
            a_in_data  = DW'(sent);
            a_in_sop   = (sent == 0);
            a_in_eop   = (sent == 63);
            a_in_empty = (sent == 63) ? 2'd2 : 2'd0;
            if (a_in_valid) begin
                if (first_push < 0) first_push = cyc;
                sent++;
            end
            #1;
            if (a_out_valid) begin
                if (a_out_data !== DW'(got)) errs++;
                if (got == 0)  first_sop = a_out_sop;
                if (got == 63) begin last_eop = a_out_eop; last_empty = a_out_empty; end
                if (got != 0 && a_out_sop !== 1'b0) errs++;
                if (got != 63 && a_out_eop !== 1'b0) errs++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                got++;
            end
        end
        @(negedge clk); a_in_valid = 1'b0; a_in_sop = 1'b0; a_in_eop = 1'b0; a_in_empty = '0;
        n_total++;
        if (got != 64) $display("FAIL stream_count: got %0d beats required 64", got); else n_pass++;
        n_total++;
        if (errs != 0) $display("FAIL stream_order: %0d bad beats required 0", errs); else n_pass++;
        n_total++;
        if (first_sop !== 1'b1 || last_eop !== 1'b1 || last_empty !== 2'd2)
            $display("FAIL stream_markers: sop0=%b eop63=%b empty63=%0d required 1/1/2", first_sop, last_eop, last_empty);
        else n_pass++;
        n_total++;
        if (first_out - first_push != 1)
            $display("FAIL stream_latency: %0d cycles required 1", first_out - first_push);
        else n_pass++;
        n_total++;
        if (last_out - first_out != 63)
            $display("FAIL stream_bubbles: span %0d cycles required 63", last_out - first_out);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int sent = 0, got = 0, errs = 0, maxcnt = 0;
        logic g1 = 1'b0, g2 = 1'b0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            @(negedge clk);
            b_in_valid = g2 && (sent < 1000);
            b_in_data  = DW'(sent);
            b_in_sop   = (sent % 16 == 0);
            b_in_eop   = (sent % 16 == 15);
            if (b_in_valid) sent++;
            g2 = g1;
            g1 = b_in_ready;
            b_out_ready = 1'($urandom_range(0, 1));
            #1;
            if (int'(dut_b.count_q) > maxcnt) maxcnt = int'(dut_b.count_q);
            if (b_out_valid) begin
                if (b_out_data !== DW'(got) || b_out_sop !== (got % 16 == 0) || b_out_eop !== (got % 16 == 15))
                    errs++;
                got++;
            end
        end
        @(negedge clk); b_in_valid = 1'b0; b_out_ready = 1'b0;
        n_total++;
        if (got != 1000) $display("FAIL bp_count: got %0d beats required 1000", got); else n_pass++;
        n_total++;
        if (errs != 0) $display("FAIL bp_order: %0d bad beats required 0", errs); else n_pass++;
        n_total++;
        if (maxcnt > 8) $display("FAIL bp_max_count: %0d required <=8", maxcnt); else n_pass++;
        n_total++;
        if (b_ovf !== 1'b0 || b_drop !== 16'd0)
            $display("FAIL bp_no_overflow: overflow_err=%b drop_count=%0d required 0/0", b_ovf, b_drop);
        else n_pass++;
    endtask

    task automatic test_full_wrap;
        int acc = 0, got = 1, errs = 0;
        c_out_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            c_in_valid = c_in_ready;
            c_in_data  = DW'(acc);
            if (c_in_valid) acc++;
        end
        @(negedge clk); c_in_valid = 1'b0; #1;
        n_total++;
        if (acc != 8 || c_in_ready !== 1'b0)
            $display("FAIL full_accept: accepted %0d in_ready=%b required 8/0", acc, c_in_ready);
        else n_pass++;
        @(negedge clk); c_out_ready = 1'b1; #1;
        n_total++;
        if (c_out_valid !== 1'b1 || c_out_data !== DW'(0) || c_in_ready !== 1'b0)
            $display("FAIL full_pop: out_valid=%b data=%0d in_ready=%b required 1/0/0", c_out_valid, c_out_data, c_in_ready);
        else n_pass++;
        @(negedge clk); c_out_ready = 1'b0; #1;
        n_total++;
        if (c_in_ready !== 1'b1 || c_out_data !== DW'(1))
            $display("FAIL full_reassert: in_ready=%b head=%0d required 1/1", c_in_ready, c_out_data);
        else n_pass++;
        for (int cyc = 0; cyc < 500 && got < 40; cyc++) begin
            @(negedge clk);
            c_in_valid  = c_in_ready && (acc < 40);
            c_in_data   = DW'(acc);
            if (c_in_valid) acc++;
            c_out_ready = (cyc % 3) != 1;
            #1;
            if (c_out_valid && c_out_ready) begin
                if (c_out_data !== DW'(got)) errs++;
                got++;
            end
        end
        @(negedge clk); c_in_valid = 1'b0; c_out_ready = 1'b0; #1;
        n_total++;
        if (got != 40 || errs != 0) $display("FAIL wrap_order: got %0d errs %0d required 40/0", got, errs); else n_pass++;
        n_total++;
        if (c_out_valid !== 1'b0) $display("FAIL wrap_drained: out_valid=%b required 0", c_out_valid); else n_pass++;
    endtask

    task automatic test_violation;
        int acc = 0;
        logic g1 = 1'b0, rdy;
        bit done = 1'b0;
        d_out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            rdy = d_in_ready;
            d_in_valid = g1;
            d_in_data  = DW'(acc);
            if (d_in_valid) acc++;
            g1 = rdy;
            if (!rdy) done = 1'b1;
        end
        @(negedge clk); d_in_valid = 1'b1; d_in_data = DW'(32'hDEAD); #1;
        n_total++;
        if (d_ovf !== 1'b0) $display("FAIL viol_pre: overflow_err=%b required 0", d_ovf); else n_pass++;
        @(negedge clk); d_in_valid = 1'b0; #1;
        n_total++;
        if (d_ovf !== 1'b1 || d_drop !== 16'd1)
            $display("FAIL viol_drop: overflow_err=%b drop_count=%0d required 1/1", d_ovf, d_drop);
        else n_pass++;
        n_total++;
        if (acc != 8 || d_out_data !== DW'(0) || dut_d.count_q !== 4'd8)
            $display("FAIL viol_fifo: pushed=%0d head=%0d count=%0d required 8/0/8", acc, d_out_data, dut_d.count_q);
        else n_pass++;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if (d_ovf !== 1'b1) $display("FAIL viol_sticky: overflow_err=%b required 1", d_ovf); else n_pass++;
        @(negedge clk); d_in_valid = 1'b1;
        repeat (70000) @(negedge clk);
        d_in_valid = 1'b0; #1;
        n_total++;
        if (d_drop !== 16'hFFFF) $display("FAIL viol_saturate: drop_count=%0d required 65535", d_drop); else n_pass++;
        n_total++;
        if (d_out_data !== DW'(0)) $display("FAIL viol_head: head=%0d required 0", d_out_data); else n_pass++;
    endtask

    task automatic test_midstream_reset;
        int stale = 0, seen = 0;
        a_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_in_valid = a_in_ready;
            a_in_data  = DW'(100 + i);
        end
        @(negedge clk); a_in_valid = 1'b0; #1;
        n_total++;
        if (dut_a.count_q !== 4'd5 || a_out_valid !== 1'b0)
            $display("FAIL mrst_fill: count=%0d out_valid=%b required 5/0", dut_a.count_q, a_out_valid);
        else n_pass++;
        @(negedge clk); reset = 1'b1; #1;
        n_total++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0)
            $display("FAIL mrst_during: in_ready=%b out_valid=%b required 0/0", a_in_ready, a_out_valid);
        else n_pass++;
        @(negedge clk); reset = 1'b0; #1;
        n_total++;
        if (dut_a.count_q !== 4'd0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
            $display("FAIL mrst_after: count=%0d out_valid=%b in_ready=%b required 0/0/1", dut_a.count_q, a_out_valid, a_in_ready);
        else n_pass++;
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (a_out_valid) stale++;
        end
        n_total++;
        if (stale != 0) $display("FAIL mrst_stale: %0d stale beats required 0", stale); else n_pass++;
        @(negedge clk); a_in_valid = 1'b1; a_in_data = DW'(32'hBEEF);
        @(negedge clk); a_in_valid = 1'b0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            #1;
            if (a_out_valid) begin
                seen = 1;
                n_total++;
                if (a_out_data !== DW'(32'hBEEF))
                    $display("FAIL mrst_fresh: data=%0h required beef", a_out_data);
                else n_pass++;
            end
            @(negedge clk);
        end
        if (seen == 0) begin
            n_total++;
            $display("FAIL mrst_fresh_timeout: no beat seen required 1");
        end
    endtask

    initial begin
        a_in_valid = 0; a_in_data = '0; a_in_sop = 0; a_in_eop = 0; a_in_empty = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_sop = 0; b_in_eop = 0; b_in_empty = '0; b_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_in_sop = 0; c_in_eop = 0; c_in_empty = '0; c_out_ready = 0;
        d_in_valid = 0; d_in_data = '0; d_in_sop = 0; d_in_eop = 0; d_in_empty = '0; d_out_ready = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_wrap();
        test_violation();
        test_midstream_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
